approx_mul_err_sweep: RTL and testbench
=======================================

# approx_mul_err_sweep

Hardware successor to the signed approximate-multiplier sweep bench. It exhaustively drives an external approximate signed multiplier (any `signed_int_mul`-style unit with a configuration mask) across every W-bit operand pair, one pair per clock. It computes the exact product internally and accumulates error statistics in registers, so characterisation runs at clock speed on silicon or FPGA rather than in simulation. Operand width, multiplier latency and mask width are parameters.

## Interface
- `W`, 8: operand width (signed, two's complement); W ≥ 2.
- `MUL_LAT`, 0: cycles from operands presented to `approx_r` valid (0 = combinational DUT).
- `MASK_W`, 6: configuration mask width.
- `SUM_W`, 4*W+1: absolute-error accumulator width; must be ≥ 4W+1, so it never overflows.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: pulse; begins a sweep when not busy.
- `conf_in`  in  MASK_W: mask to apply during the sweep.
- `conf_out`  out  MASK_W: latched mask to the DUT `Conf_Bit_Mask`.
- `op_a`, `op_b`  out  W signed: operands to the DUT.
- `approx_r`  in  2W signed: DUT product.
- `busy`  out  1: sweep in progress.
- `done`  out  1: sticky; stats final.
- `err_count`  out  2W+1: pairs with approx ≠ exact.
- `over_count`  out  2W+1: pairs with approx > exact.
- `abs_err_sum`  out  SUM_W: Σ|approx − exact|.
- `max_abs_err`  out  2W+1: largest |approx − exact|.
- `max_a`, `max_b`  out  W signed: operands of the first pair reaching `max_abs_err`.

## Operation
- Reset value of every output and internal register is 0. State resets to IDLE.
- States are IDLE, RUN, DRAIN and DONE.
- **IDLE or DONE, `start`=1:**
  - Latch `conf_in` into `conf_out`.
  - Clear all stats and `done`.
  - Set `op_a` = `op_b` = −2^(W−1) and `busy` = 1.
  - Go to RUN.
- **RUN:**
  - One pair is issued per cycle. `op_b` increments.
  - When `op_b` = 2^(W−1)−1, it wraps to −2^(W−1) and `op_a` increments.
  - The last pair is (2^(W−1)−1, 2^(W−1)−1); the full range is covered with no skipped values, N = 2^(2W) pairs.
  - After the last pair is issued, go to DRAIN (or straight to DONE when the final accumulate coincides).
- **Operand tracking:** the exact product and operands travel through a MUL_LAT-deep valid-tagged delay line, aligned with `approx_r`.
- **Accumulate stage (one register stage), when the aligned valid bit is set:**
  - Compute e = approx_r − exact in 2W+1 bits signed.
  - If e ≠ 0, increment `err_count`. If e > 0, also increment `over_count`.
  - `abs_err_sum` += |e|.
  - If |e| > `max_abs_err` (strict), update `max_abs_err`, `max_a` and `max_b`; ties keep the earlier pair.
- **DONE:**
  - `busy` = 0, `done` = 1, and stats hold.
  - `op_a`, `op_b` and `conf_out` hold their last values.
- `start` while `busy` is ignored.
- `start` in DONE restarts the sweep and clears stats.
- `rst` at any point, including mid-sweep, returns to IDLE with all outputs 0 on the next edge. Pending pipeline entries are discarded.
- `conf_out` is constant for the whole sweep. `conf_in` changes during a sweep have no effect.

## Timing
- Number edges from the edge that samples `start` (edge 0).
- Pair k (k = 0..N−1) is on `op_a`/`op_b` during cycle k, i.e. after edge k.
- `approx_r` for pair k is sampled at edge k+1+MUL_LAT, and the stats include pair k after that edge.
- The final pair is accumulated at edge N+MUL_LAT. At that same edge `done` becomes 1 and `busy` becomes 0.
- Sweep latency is N+MUL_LAT cycles. Throughput is one pair per cycle with no bubbles.
- The earliest restart is `start` sampled at edge N+MUL_LAT+1.

## Test plan
- W=2, MUL_LAT=0, DUT exact multiplier:
  - err_count=0, over_count=0, abs_err_sum=0, max_abs_err=0, max_a=max_b=0.
  - done rises 16 cycles after the start edge.
- W=2, DUT returns 0:
  - err_count=9, over_count=4, abs_err_sum=16.
  - max_abs_err=4 with max_a=−2, max_b=−2.
- W=2, DUT returns exact+1:
  - err_count=16, over_count=16, abs_err_sum=16.
  - max_abs_err=1 with max_a=max_b=−2 (first-pair tie rule).
- W=8, MUL_LAT=2, DUT exact with a 2-cycle pipeline:
  - err_count=0.
  - done exactly 65538 cycles after the start edge.
  - conf_out equals conf_in at start, unchanged despite conf_in toggling mid-sweep.
- W=2, rst asserted at cycle 7 of a sweep:
  - Next edge: all outputs 0, busy=0.
  - A subsequent start yields results identical to an uninterrupted run.
  - A start pulse at cycle 3 of a sweep has no effect.
  - A start in DONE clears stats and reruns.

Source files
------------

// File: rtl/approx_mul_err_sweep_if.sv
// Bus between the sweep controller and the harness around it: start/config,
// the operand/product exchange with the external multiplier, and the stats.
interface approx_mul_err_sweep_if #(
  parameter int W      = 8,
  parameter int MASK_W = 6,
  parameter int SUM_W  = 4*W+1
);
  logic                    start;
  logic [MASK_W-1:0]       conf_in;
  logic [MASK_W-1:0]       conf_out;
  logic signed [W-1:0]     op_a;
  logic signed [W-1:0]     op_b;
  logic signed [2*W-1:0]   approx_r;
  logic                    busy;
  logic                    done;
  logic [2*W:0]            err_count;
  logic [2*W:0]            over_count;
  logic [SUM_W-1:0]        abs_err_sum;
  logic [2*W:0]            max_abs_err;
  logic signed [W-1:0]     max_a;
  logic signed [W-1:0]     max_b;

  // Harness side: drives start/config and returns the approximate product.
  modport master (
    output start, conf_in, approx_r,
    input  conf_out, op_a, op_b, busy, done,
    input  err_count, over_count, abs_err_sum, max_abs_err, max_a, max_b
  );

  // Sweep controller side.
  modport slave (
    input  start, conf_in, approx_r,
    output conf_out, op_a, op_b, busy, done,
    output err_count, over_count, abs_err_sum, max_abs_err, max_a, max_b
  );
endinterface

// File: rtl/approx_mul_err_sweep.sv
// Exhaustive signed operand sweep for an external approximate multiplier.
// Issues one operand pair per clock, computes the exact product on-chip,
// aligns it with the multiplier's MUL_LAT-cycle latency and accumulates
// error statistics (count, over-count, |e| sum, max |e| with operands).
module approx_mul_err_sweep #(
  parameter int W       = 8,
  parameter int MUL_LAT = 0,
  parameter int MASK_W  = 6,
  parameter int SUM_W   = 4*W+1
) (
  input  logic                  clk,
  input  logic                  rst,
  approx_mul_err_sweep_if.slave bus
);
  localparam int PW = 2*W;
  localparam int EW = 2*W+1;
  localparam logic signed [W-1:0] OP_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] OP_MAX = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  // One in-flight pair: operands and exact product, tagged valid.
  typedef struct packed {
    logic                 vld;
    logic signed [W-1:0]  a;
    logic signed [W-1:0]  b;
    logic signed [PW-1:0] exact;
  } tag_t;

  state_e state_q, state_d;

  logic signed [W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [MASK_W-1:0]   conf_q, conf_d;
  logic [EW-1:0]       err_q, err_d, over_q, over_d, max_q, max_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic signed [W-1:0] ma_q, ma_d, mb_q, mb_d;

  logic start_go, last_issue, last_acc;
  tag_t issue_tag, acc_tag;

  logic signed [PW-1:0] a_ext, b_ext;
  logic signed [EW-1:0] appr_e, exact_e, err_e;
  logic [EW-1:0]        abs_e;
  logic                 err_nz, err_pos;

  assign start_go   = bus.start && (state_q == IDLE || state_q == DONE);
  assign last_issue = (state_q == RUN) && (op_a_q == OP_MAX) && (op_b_q == OP_MAX);

  // Exact reference for the pair currently on the operand bus.
  assign a_ext = op_a_q;
  assign b_ext = op_b_q;

  always_comb begin
    issue_tag       = '0;
    issue_tag.vld   = (state_q == RUN);
    issue_tag.a     = op_a_q;
    issue_tag.b     = op_b_q;
    issue_tag.exact = a_ext * b_ext;
  end

  // Delay line matching the external multiplier latency; a zero-latency
  // multiplier is compared against the pair it is being driven with.
  generate
    if (MUL_LAT == 0) begin : g_nodly
      assign acc_tag = issue_tag;
    end else begin : g_dly
      tag_t dly_q [MUL_LAT];

      // Shift pair tags along; reset drops anything in flight.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < MUL_LAT; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= issue_tag;
          for (int i = 1; i < MUL_LAT; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign acc_tag = dly_q[MUL_LAT-1];
    end
  endgenerate

  assign last_acc = acc_tag.vld && (acc_tag.a == OP_MAX) && (acc_tag.b == OP_MAX);

  // Signed error in 2W+1 bits; |e| stays below 2^(2W) so negation is safe.
  assign appr_e  = {bus.approx_r[PW-1], bus.approx_r};
  assign exact_e = {acc_tag.exact[PW-1], acc_tag.exact};
  assign err_e   = appr_e - exact_e;
  assign abs_e   = err_e[EW-1] ? -err_e : err_e;
  assign err_nz  = (err_e != '0);
  assign err_pos = err_nz && !err_e[EW-1];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: RUN until the last pair is issued, DRAIN until it is
  // accumulated (skipped when both happen in the same cycle).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = RUN;
      RUN: begin
        if (last_acc)        state_d = DONE;
        else if (last_issue) state_d = DRAIN;
      end
      DRAIN: if (last_acc) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Operand counter (b inner, a outer) and mask latch.
  always_comb begin
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    conf_d = conf_q;
    if (start_go) begin
      conf_d = bus.conf_in;
      op_a_d = OP_MIN;
      op_b_d = OP_MIN;
    end else if (state_q == RUN && !last_issue) begin
      if (op_b_q == OP_MAX) begin
        op_b_d = OP_MIN;
        op_a_d = op_a_q + W'(1);
      end else begin
        op_b_d = op_b_q + W'(1);
      end
    end
  end

  // Statistics update for the aligned pair; a new sweep clears everything.
  always_comb begin
    err_d  = err_q;
    over_d = over_q;
    sum_d  = sum_q;
    max_d  = max_q;
    ma_d   = ma_q;
    mb_d   = mb_q;
    if (start_go) begin
      err_d  = '0;
      over_d = '0;
      sum_d  = '0;
      max_d  = '0;
      ma_d   = '0;
      mb_d   = '0;
    end else if (acc_tag.vld) begin
      if (err_nz)  err_d  = err_q + EW'(1);
      if (err_pos) over_d = over_q + EW'(1);
      sum_d = sum_q + SUM_W'(abs_e);
      // Strict compare: ties keep the earliest pair.
      if (abs_e > max_q) begin
        max_d = abs_e;
        ma_d  = acc_tag.a;
        mb_d  = acc_tag.b;
      end
    end
  end

  // Datapath and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q <= '0;
      op_b_q <= '0;
      conf_q <= '0;
      err_q  <= '0;
      over_q <= '0;
      sum_q  <= '0;
      max_q  <= '0;
      ma_q   <= '0;
      mb_q   <= '0;
    end else begin
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      conf_q <= conf_d;
      err_q  <= err_d;
      over_q <= over_d;
      sum_q  <= sum_d;
      max_q  <= max_d;
      ma_q   <= ma_d;
      mb_q   <= mb_d;
    end
  end

  assign bus.conf_out    = conf_q;
  assign bus.op_a        = op_a_q;
  assign bus.op_b        = op_b_q;
  assign bus.busy        = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done        = (state_q == DONE);
  assign bus.err_count   = err_q;
  assign bus.over_count  = over_q;
  assign bus.abs_err_sum = sum_q;
  assign bus.max_abs_err = max_q;
  assign bus.max_a       = ma_q;
  assign bus.max_b       = mb_q;
endmodule

// File: tb/tb_approx_mul_err_sweep.sv
// Bench: two sweep controllers (W=2/lat 0 and W=8/lat 2) each driving a
// behavioural approximate multiplier whose error mode comes from conf_out.
// A cycle-level reference model per lane is compared every cycle.
module tb_approx_mul_err_sweep;
  localparam int MW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic st0 = 1'b0, st1 = 1'b0, rs0 = 1'b1, rs1 = 1'b1;
  logic [MW-1:0] cf0 = '0, cf1 = '0;

  longint o_a [2], o_b [2], o_conf [2], o_err [2], o_over [2];
  longint o_sum [2], o_max [2], o_ma [2], o_mb [2];
  logic   o_busy [2], o_done [2];

  typedef struct {
    longint err, over, sum, mx, ma, mb;
  } stats_t;

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Multiplier behaviour selected by mask: [1:0] mode, [5:2] error seed.
  function automatic longint approx_fn(int w, longint conf, longint a, longint b);
    longint p, h, seed;
    p = a * b;
    seed = conf / 4;
    case (conf % 4)
      0: return p;
      1: return 0;
      2: return p + 1;
      default: begin
        h = ((a + 128) * 131 + (b + 128) * 37 + seed * 17) % 97;
        if (h % 5 == 0 || h % 7 == 1) return p + (h % 7) - 3;
        return p;
      end
    endcase
  endfunction

  function automatic void acc(inout stats_t s, input int w, input longint conf,
                              input longint a, input longint b);
    longint e, ae;
    e  = approx_fn(w, conf, a, b) - a * b;
    ae = (e < 0) ? -e : e;
    if (e != 0) s.err++;
    if (e > 0)  s.over++;
    s.sum += ae;
    if (ae > s.mx) begin
      s.mx = ae;
      s.ma = a;
      s.mb = b;
    end
  endfunction

  function automatic stats_t full_stats(int w, longint conf);
    stats_t s;
    longint h;
    s = '{default: 0};
    h = longint'(1) << (w - 1);
    for (longint a = -h; a < h; a++)
      for (longint b = -h; b < h; b++)
        acc(s, w, conf, a, b);
    return s;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int     LW = (g == 0) ? 2 : 8;
    localparam int     LL = (g == 0) ? 0 : 2;
    localparam int     PW = 2 * LW;
    localparam longint NP = longint'(1) << (2 * LW);
    localparam longint H  = longint'(1) << (LW - 1);

    logic          rs, st;
    logic [MW-1:0] cf;
    assign rs = (g == 0) ? rs0 : rs1;
    assign st = (g == 0) ? st0 : st1;
    assign cf = (g == 0) ? cf0 : cf1;

    approx_mul_err_sweep_if #(.W(LW), .MASK_W(MW), .SUM_W(4*LW+1)) bus ();

    approx_mul_err_sweep #(.W(LW), .MUL_LAT(LL), .MASK_W(MW), .SUM_W(4*LW+1)) dut (
      .clk (clk),
      .rst (rs),
      .bus (bus)
    );

    assign bus.start   = st;
    assign bus.conf_in = cf;

    logic signed [PW-1:0] mul_now;
    assign mul_now = PW'(approx_fn(LW, longint'(bus.conf_out),
                                   longint'(bus.op_a), longint'(bus.op_b)));
    if (LL == 0) begin : g_m0
      assign bus.approx_r = mul_now;
    end else begin : g_mp
      logic signed [PW-1:0] mq [LL];
      always @(posedge clk) begin
        mq[0] <= mul_now;
        for (int i = 1; i < LL; i++) mq[i] <= mq[i-1];
      end
      assign bus.approx_r = mq[LL-1];
    end

    assign o_a[g]    = longint'(bus.op_a);
    assign o_b[g]    = longint'(bus.op_b);
    assign o_conf[g] = longint'(bus.conf_out);
    assign o_err[g]  = longint'(bus.err_count);
    assign o_over[g] = longint'(bus.over_count);
    assign o_sum[g]  = longint'(bus.abs_err_sum);
    assign o_max[g]  = longint'(bus.max_abs_err);
    assign o_ma[g]   = longint'(bus.max_a);
    assign o_mb[g]   = longint'(bus.max_b);
    assign o_busy[g] = bus.busy;
    assign o_done[g] = bus.done;

    // Reference: edge count n since the accepted start; pair j = n-LL-1 is
    // folded in at edge n, operands show pair min(n, N-1).
    bit     armed = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    longint n = 0, m_conf = 0, m_a = 0, m_b = 0, j, p;
    stats_t m = '{default: 0};

    always @(posedge clk) begin
      if (rs) begin
        armed = 1'b1; m_busy = 1'b0; m_done = 1'b0;
        n = 0; m_conf = 0; m_a = 0; m_b = 0; m = '{default: 0};
      end else if (st && !m_busy) begin
        m_busy = 1'b1; m_done = 1'b0; n = 0; m_conf = longint'(cf);
        m = '{default: 0}; m_a = -H; m_b = -H;
      end else if (m_busy) begin
        n++;
        j = n - LL - 1;
        if (j >= 0) acc(m, LW, m_conf, -H + j / (2 * H), -H + j % (2 * H));
        p = (n < NP) ? n : NP - 1;
        m_a = -H + p / (2 * H);
        m_b = -H + p % (2 * H);
        if (n == NP + LL) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end

    always @(negedge clk) begin
      if (armed) begin
        check($sformatf("L%0d busy", g), longint'(o_busy[g]), longint'(m_busy));
        check($sformatf("L%0d done", g), longint'(o_done[g]), longint'(m_done));
        check($sformatf("L%0d op_a", g), o_a[g], m_a);
        check($sformatf("L%0d op_b", g), o_b[g], m_b);
        check($sformatf("L%0d conf_out", g), o_conf[g], m_conf);
        check($sformatf("L%0d err_count", g), o_err[g], m.err);
        check($sformatf("L%0d over_count", g), o_over[g], m.over);
        check($sformatf("L%0d abs_err_sum", g), o_sum[g], m.sum);
        check($sformatf("L%0d max_abs_err", g), o_max[g], m.mx);
        check($sformatf("L%0d max_a", g), o_ma[g], m.ma);
        check($sformatf("L%0d max_b", g), o_mb[g], m.mb);
      end
    end
  end

  task automatic cyc(int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_done0(int limit, string nm);
    int c = 0;
    while (!o_done[0] && c < limit) begin
      cyc(1);
      c++;
    end
    check({nm, " done reached"}, longint'(o_done[0]), 1);
  endtask

  task automatic check_final0(string nm, longint e, longint o, longint s,
                              longint mx, longint ma, longint mb);
    check({nm, " err_count"}, o_err[0], e);
    check({nm, " over_count"}, o_over[0], o);
    check({nm, " abs_err_sum"}, o_sum[0], s);
    check({nm, " max_abs_err"}, o_max[0], mx);
    check({nm, " max_a"}, o_ma[0], ma);
    check({nm, " max_b"}, o_mb[0], mb);
  endtask

  task automatic check_zero0(string nm);
    check({nm, " busy"}, longint'(o_busy[0]), 0);
    check({nm, " done"}, longint'(o_done[0]), 0);
    check({nm, " op_a"}, o_a[0], 0);
    check({nm, " op_b"}, o_b[0], 0);
    check({nm, " conf_out"}, o_conf[0], 0);
    check_final0(nm, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    fork
      begin : seq_w2
        stats_t s;
        logic [MW-1:0] saved;
        cyc(3);
        rs0 = 1'b0;
        check_zero0("L0 reset");

        // Exact multiplier, stray start at cycle 3, conf_in toggled mid-sweep.
        cf0 = 6'h00;
        st0 = 1'b1; cyc(1); st0 = 1'b0;
        cyc(2);
        st0 = 1'b1; cyc(1); st0 = 1'b0;
        cf0 = 6'h3f;
        cyc(12);
        check("L0 exact done@15", longint'(o_done[0]), 0);
        check("L0 exact busy@15", longint'(o_busy[0]), 1);
        cyc(1);
        check("L0 exact done@16", longint'(o_done[0]), 1);
        check("L0 exact busy@16", longint'(o_busy[0]), 0);
        check("L0 exact conf_out", o_conf[0], 0);
        check_final0("L0 exact", 0, 0, 0, 0, 0, 0);

        // Multiplier returning 0; restart from DONE.
        cf0 = 6'h01;
        st0 = 1'b1; cyc(1); st0 = 1'b0;
        cf0 = 6'h2a;
        wait_done0(40, "L0 zero");
        check_final0("L0 zero", 9, 4, 16, 4, -2, -2);
        s = full_stats(2, 1);
        check("L0 model zero err", s.err, 9);
        check("L0 model zero sum", s.sum, 16);

        // Exact+1; start in DONE must clear the previous stats.
        cf0 = 6'h02;
        st0 = 1'b1; cyc(1); st0 = 1'b0;
        check("L0 restart err cleared", o_err[0], 0);
        check("L0 restart max cleared", o_max[0], 0);
        check("L0 restart done cleared", longint'(o_done[0]), 0);
        wait_done0(40, "L0 plus1");
        check_final0("L0 plus1", 16, 16, 16, 1, -2, -2);
        s = full_stats(2, 2);
        check("L0 model plus1 over", s.over, 16);
        check("L0 model plus1 max_a", s.ma, -2);

        // Random masks, random gaps (including back-to-back restart),
        // random start noise and conf_in noise during the sweep.
        for (int r = 0; r < 10; r++) begin
          int c;
          saved = MW'($urandom);
          if (r % 2 == 0) saved[1:0] = 2'b11;
          cf0 = saved;
          cyc($urandom_range(0, 2));
          st0 = 1'b1; cyc(1); st0 = 1'b0;
          c = 0;
          while (!o_done[0] && c < 64) begin
            st0 = ($urandom_range(0, 3) == 0);
            cf0 = MW'($urandom);
            cyc(1);
            c++;
          end
          st0 = 1'b0;
          check("L0 rand done reached", longint'(o_done[0]), 1);
          s = full_stats(2, longint'(saved));
          check_final0($sformatf("L0 rand%0d", r), s.err, s.over, s.sum, s.mx, s.ma, s.mb);
          check("L0 rand conf_out", o_conf[0], longint'(saved));
        end

        // Reset at cycle 7 of a sweep, then an uninterrupted rerun.
        saved = 6'h27;
        cf0 = saved;
        cyc(1);
        st0 = 1'b1; cyc(1); st0 = 1'b0;
        cyc(6);
        rs0 = 1'b1; cyc(1); rs0 = 1'b0;
        check_zero0("L0 midrst");
        cyc(2);
        st0 = 1'b1; cyc(1); st0 = 1'b0;
        wait_done0(40, "L0 after rst");
        s = full_stats(2, longint'(saved));
        check_final0("L0 after rst", s.err, s.over, s.sum, s.mx, s.ma, s.mb);
        cyc(3);
      end
      begin : seq_w8
        cyc(3);
        rs1 = 1'b0;
        cf1 = 6'h14;
        st1 = 1'b1; cyc(1); st1 = 1'b0;
        cyc(100);
        cf1 = 6'h2b;
        cyc(30000);
        cf1 = 6'h01;
        cyc(35437);
        check("L1 done@65537", longint'(o_done[1]), 0);
        check("L1 busy@65537", longint'(o_busy[1]), 1);
        cyc(1);
        check("L1 done@65538", longint'(o_done[1]), 1);
        check("L1 busy@65538", longint'(o_busy[1]), 0);
        check("L1 err_count", o_err[1], 0);
        check("L1 abs_err_sum", o_sum[1], 0);
        check("L1 conf_out", o_conf[1], 64'h14);
        check("L1 op_a last", o_a[1], 127);
        check("L1 op_b last", o_b[1], 127);
        cyc(3);
      end
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
